qracc_sram_arbiter: RTL
=======================

# qracc_sram_arbiter

Parametrised N-port front end for the QRAcc weight SRAM controller: arbitrates `numPorts` request channels onto the single downstream SRAM request channel and routes in-order read data back to the originating port. It sits between the CSR/DMA/feature-loader masters and the SRAM slave port, replacing point-to-point wiring. It generalises the single-master SRAM handshake to multiple channels, adds round-robin or fixed-priority selection, and tracks up to `maxOutstanding` pending reads.

## Interface
- `numPorts`, 4: upstream request channels (2..8)
- `numRows`, 128: SRAM rows; `addrBits = $clog2(numRows)`
- `numCols`, 32: SRAM word width
- `maxOutstanding`, 4: read-tag FIFO depth (power of two, ≥2)
- `clk` in 1: sole clock, rising edge
- `rst` in 1: reset is synchronous and active-high
- `prio_mode_i` in 1: 0 = round-robin, 1 = fixed priority (port 0 highest)
- `up_rq_valid_i` in numPorts: per-port request valid
- `up_rq_wr_i` in numPorts: per-port write (1) / read (0)
- `up_addr_i` in numPorts*addrBits: per-port address, port p at `[p*addrBits +: addrBits]`
- `up_wr_data_i` in numPorts*numCols: per-port write data, same packing
- `up_rq_ready_o` out numPorts: one-hot grant ANDed with downstream ready
- `up_rd_valid_o` out numPorts: one-hot read-return strobe
- `up_rd_data_o` out numCols: read data, broadcast to all ports
- `dn_rq_valid_o`, `dn_rq_wr_o` out 1; `dn_addr_o` out addrBits; `dn_wr_data_o` out numCols: downstream request
- `dn_rq_ready_i`, `dn_rd_valid_i` in 1; `dn_rd_data_i` in numCols: downstream response
- `outstanding_o` out $clog2(maxOutstanding)+1: pending read count
- `err_o` out 1: sticky, downstream `rd_valid` with no pending read

## Operation
- Eligible port: `up_rq_valid_i[p]` and (write, or tag FIFO not full).
- Round-robin: search eligible ports starting at `rr_ptr`, wrapping at numPorts−1→0. On an accepted handshake (`dn_rq_valid_o & dn_rq_ready_i`) with grant g, `rr_ptr ← (g+1) mod numPorts`.
- Fixed priority: lowest eligible index wins; `rr_ptr` holds.
- `prio_mode_i` may change any cycle and takes effect the same cycle.
- Grant g drives all `dn_*` request fields; `dn_rq_valid_o` = any eligible. `up_rq_ready_o[g] = dn_rq_ready_i`; other bits 0.
- Accepted read pushes g into the tag FIFO. Writes push nothing and produce no return.
- `dn_rd_valid_i`: pop head tag h, assert `up_rd_valid_o[h]`, pass `dn_rd_data_i` through.
- Full check uses the registered count only; a same-cycle pop does not free a slot for a same-cycle push.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- `dn_rd_valid_i` with an empty FIFO: no pop, no strobe, `err_o ← 1` until reset.
- A request held valid but not granted must stay stable until accepted; the arbiter does not check this.

## Timing
- Request path is combinational, with zero added latency from `up_*` to `dn_*`.
- Read return path is combinational from `dn_rd_valid_i` to `up_rd_valid_o`.
- Downstream must assert `rd_valid` ≥1 cycle after the accepting edge. Returns are in order.
- State updates (`rr_ptr`, FIFO, count, `err_o`) occur on the rising `clk` edge.
- Reset values: `rr_ptr = 0`, FIFO empty, `outstanding_o = 0`, `err_o = 0`.
- While `rst` is high, `dn_rq_valid_o`, `up_rq_ready_o` and `up_rd_valid_o` are forced to 0.
- Reset mid-operation discards pending tags. Late downstream returns after reset set `err_o`.
- Throughput is one request per cycle when `dn_rq_ready_i` stays high.

## Structure
- `qracc_pkg` gains the `qracc_arb_mode_t` enum (`ARB_RR = 0`, `ARB_FIXED = 1`) and a default `qracc_arb_ports` constant.
- Sub-module `qracc_tag_fifo`: synchronous FIFO (width `$clog2(numPorts)`, depth `maxOutstanding`) with `full`, `empty` and `count` outputs.
- The arbiter core (rotate, priority-encode, un-rotate) stays inline.

## Test plan
- Ports 0–3 all request reads continuously, `dn_rq_ready_i = 1`, RR mode → grants 0,1,2,3,0; returns strobe the same order.
- Fixed mode, ports 1 and 3 both valid → port 1 granted every cycle; port 3 starved; `rr_ptr` unchanged.
- 4 reads accepted with no return → `outstanding_o = 4`, read requests blocked, write from port 2 still granted. One return → next read accepted the cycle after.
- `dn_rq_ready_i = 0` for 3 cycles with port 2 valid → `up_rq_ready_o = 0`, no push, `rr_ptr` held.
- Port 1 reads addr 5, downstream returns 0xDEADBEEF → `up_rd_valid_o = 4'b0010`, `up_rd_data_o = 0xDEADBEEF`.
- `dn_rd_valid_i` with the FIFO empty → `err_o = 1` and stays set until `rst`. Assert `rst` with 2 reads pending → `outstanding_o = 0` next cycle.

Source files
------------

// File: rtl/qracc_pkg.sv
// Shared types and defaults for the QRAcc weight SRAM front end.
package qracc_pkg;

  // Arbitration policy selected by prio_mode_i.
  typedef enum logic {
    ARB_RR    = 1'b0,
    ARB_FIXED = 1'b1
  } qracc_arb_mode_t;

  // Default number of upstream masters (CSR, DMA, feature loader, spare).
  localparam int unsigned qracc_arb_ports = 4;

endpackage

// File: rtl/qracc_tag_fifo.sv
// Synchronous FIFO holding the originating port of each pending read.
// Push is ignored when full and pop is ignored when empty.
module qracc_tag_fifo #(
  parameter int unsigned Width = 2,
  parameter int unsigned Depth = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [Width-1:0]         push_data,
  input  logic                     pop,
  output logic [Width-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(Depth):0]   count
);

  localparam int unsigned PtrBits = $clog2(Depth);
  localparam int unsigned CntBits = PtrBits + 1;

  logic [Width-1:0]   mem [Depth];
  logic [PtrBits-1:0] wr_ptr_q;
  logic [PtrBits-1:0] rd_ptr_q;
  logic [CntBits-1:0] count_q;
  logic               do_push;
  logic               do_pop;

  // Qualify requests against the registered occupancy.
  always_comb begin
    full     = (count_q == CntBits'(Depth));
    empty    = (count_q == '0);
    do_push  = push & ~full;
    do_pop   = pop & ~empty;
    pop_data = mem[rd_ptr_q];
    count    = count_q;
  end

  // Pointer and occupancy state; depth is a power of two so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrBits'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrBits'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntBits'(1);
        2'b01:   count_q <= count_q - CntBits'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/qracc_sram_arbiter.sv
// N-port arbiter in front of the QRAcc weight SRAM. Selects one upstream request per cycle
// (round-robin or fixed priority), forwards it combinationally, and steers in-order read
// returns back to the requesting port using a tag FIFO.
module qracc_sram_arbiter
  import qracc_pkg::*;
#(
  parameter int unsigned numPorts       = qracc_arb_ports,
  parameter int unsigned numRows        = 128,
  parameter int unsigned numCols        = 32,
  parameter int unsigned maxOutstanding = 4,
  localparam int unsigned addrBits      = $clog2(numRows),
  localparam int unsigned cntBits       = $clog2(maxOutstanding) + 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         prio_mode_i,
  input  logic [numPorts-1:0]          up_rq_valid_i,
  input  logic [numPorts-1:0]          up_rq_wr_i,
  input  logic [numPorts*addrBits-1:0] up_addr_i,
  input  logic [numPorts*numCols-1:0]  up_wr_data_i,
  output logic [numPorts-1:0]          up_rq_ready_o,
  output logic [numPorts-1:0]          up_rd_valid_o,
  output logic [numCols-1:0]           up_rd_data_o,
  output logic                         dn_rq_valid_o,
  output logic                         dn_rq_wr_o,
  output logic [addrBits-1:0]          dn_addr_o,
  output logic [numCols-1:0]           dn_wr_data_o,
  input  logic                         dn_rq_ready_i,
  input  logic                         dn_rd_valid_i,
  input  logic [numCols-1:0]           dn_rd_data_i,
  output logic [cntBits-1:0]           outstanding_o,
  output logic                         err_o
);

  localparam int unsigned tagBits = $clog2(numPorts);

  qracc_arb_mode_t     arb_mode;
  logic [tagBits-1:0]  rr_ptr_q;
  logic [tagBits-1:0]  rr_ptr_d;
  logic [tagBits-1:0]  base;
  logic [tagBits-1:0]  grant;
  logic [numPorts-1:0] eligible;
  logic                any_elig;
  int unsigned         arb_idx;
  logic                accept;
  logic                push;
  logic                pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [tagBits-1:0]  head_tag;
  logic                err_q;

  assign arb_mode = qracc_arb_mode_t'(prio_mode_i);

  // Eligibility, then a rotated priority search starting at base; the search index is
  // mapped straight back to a port number, folding rotate/encode/un-rotate together.
  always_comb begin
    eligible = up_rq_valid_i & (up_rq_wr_i | {numPorts{~fifo_full}});
    any_elig = |eligible;
    base     = (arb_mode == ARB_FIXED) ? '0 : rr_ptr_q;
    grant    = '0;
    arb_idx  = 0;
    for (int unsigned i = numPorts; i > 0; i--) begin
      // Walk from the lowest-priority offset down so the highest-priority hit wins last.
      arb_idx = (32'(base) + i - 1) % numPorts;
      if (eligible[arb_idx]) grant = arb_idx[tagBits-1:0];
    end
  end

  // Downstream request mux and upstream handshake; everything gated off while in reset.
  always_comb begin
    dn_rq_valid_o = any_elig & ~rst;
    dn_rq_wr_o    = 1'b0;
    dn_addr_o     = '0;
    dn_wr_data_o  = '0;
    for (int unsigned p = 0; p < numPorts; p++) begin
      if (grant == tagBits'(p)) begin
        dn_rq_wr_o   = up_rq_wr_i[p];
        dn_addr_o    = up_addr_i[p*addrBits +: addrBits];
        dn_wr_data_o = up_wr_data_i[p*numCols +: numCols];
      end
    end
    up_rq_ready_o = '0;
    if (dn_rq_valid_o) up_rq_ready_o[grant] = dn_rq_ready_i;
    accept = dn_rq_valid_o & dn_rq_ready_i;
    push   = accept & ~dn_rq_wr_o;
  end

  // Read return steering; a return with nothing pending is dropped and flagged.
  always_comb begin
    pop           = dn_rd_valid_i & ~fifo_empty & ~rst;
    up_rd_valid_o = '0;
    if (pop) up_rd_valid_o[head_tag] = 1'b1;
    up_rd_data_o  = dn_rd_data_i;
  end

  // Round-robin pointer advances past the winner only on an accepted RR-mode grant.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept && arb_mode == ARB_RR) begin
      rr_ptr_d = (grant == tagBits'(numPorts - 1)) ? '0 : grant + tagBits'(1);
    end
  end

  // Pointer and sticky error state.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
      err_q    <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      if (dn_rd_valid_i && fifo_empty) err_q <= 1'b1;
    end
  end

  assign err_o = err_q;

  qracc_tag_fifo #(
    .Width (tagBits),
    .Depth (maxOutstanding)
  ) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (grant),
    .pop       (pop),
    .pop_data  (head_tag),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (outstanding_o)
  );

endmodule
